axi_sram_bridge: RTL and testbench
==================================

Name: axi_sram_bridge

Overview:
Converts the pipeline's two SRAM-like memory ports, instruction fetch (read-only) and data load/store, into a single AXI3 master port, one transaction outstanding at a time. Sits between the pipeline and the external AXI interface inside mycpu_core. Its AXI signals connect straight to the core's top-level AXI ports.

Parameters:
INST_ID, 4'd0, ARID used for instruction reads
DATA_ID, 4'd1, ARID/AWID/WID used for data transactions

Ports:
clk  in  1  core clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
inst_req  in  1  fetch request; held with inst_addr until inst_done
inst_addr  in  32  fetch address, word aligned
inst_rdata  out  32  fetched word, valid with inst_done, held until next inst_done
inst_done  out  1  one-cycle completion pulse
data_req  in  1  data request; held with all data_* inputs until data_done
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 byte, 1 half, 2 word (drives arsize/awsize)
data_addr  in  32  byte address
data_wstrb  in  4  store byte enables
data_wdata  in  32  store data
data_rdata  out  32  load word, valid with data_done, held until next data_done
data_done  out  1  one-cycle completion pulse
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/4/3/2/2/4/3/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1
bid/bresp/bvalid  in  4/2/1  AXI write response
bready  out  1

Behaviour:
- Reset (rst=1 at clock edge): FSM to IDLE; arvalid, awvalid, wvalid, rready, bready, inst_done, data_done = 0; inst_rdata, data_rdata = 0; araddr/awaddr/wdata/wstrb = 0. Reset mid-transaction abandons it, with no done pulse and no further AXI activity.
- Constants: arlen=awlen=0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0, wlast=1, awid=wid=DATA_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: if data_req, latch data fields and go to RD_ADDR (data_wr=0) or WR_REQ (data_wr=1). Otherwise, if inst_req, latch inst_addr, arid=INST_ID, arsize=2, and go to RD_ADDR. Data has fixed priority over inst. AXI outputs are registered, so valid rises the cycle after the request is sampled.
- RD_ADDR: arvalid=1. On arvalid&arready, arvalid drops next cycle and rready is set. Go to RD_DATA.
- RD_DATA: rready=1. On rvalid&rready, capture rdata into inst_rdata or data_rdata (by the latched source), pulse that port's done next cycle, clear rready, go to IDLE. rid, rresp and rlast are ignored; there is only one outstanding transaction.
- WR_REQ: awvalid=1 and wvalid=1 together. Each drops independently on its own handshake, and the handshakes may occur in either order or in the same cycle. When both are complete, set bready and go to WR_RESP.
- WR_RESP: bready=1. On bvalid, pulse data_done next cycle, clear bready, go to IDLE. bresp is ignored.
- Done pulse is high exactly one cycle. The FSM is in IDLE during the done cycle, and the requester changes or drops req in that same cycle. IDLE samples req in the done cycle, so a new request from the requester is sampled then; a held stale req would re-issue. Requester contract: deassert or replace req in the done cycle.
- Minimum latency (ready/valid asserted immediately): req sampled in cycle 0, arvalid in cycle 1, rvalid accepted in cycle 2, done in cycle 3.
- Size/strobe passthrough: awsize=data_size; wstrb=data_wstrb unmodified; araddr/awaddr unaligned byte address passed as given.
- No request is ever dropped. A waiting inst_req is served as soon as the FSM returns to IDLE with data_req low.

Test Plan:
- Inst fetch 0xBFC00000, arready delayed 2 cycles, rvalid 3 cycles after AR handshake with rdata=0x3C08BFC0 -> single AR with arid=0, arsize=2, arlen=0; inst_done pulses once; inst_rdata=0x3C08BFC0.
- Store byte 0xAB to 0x80001003, wstrb=4'b1000, awready 3 cycles after wready -> awsize=0, wvalid drops after its own handshake, bready rises only after both; data_done one pulse after bvalid.
- inst_req and data load (0x80000010) asserted in the same cycle -> data AR (arid=1) issued first; inst AR issued only after data_done; both rdata correct.
- Back-to-back loads: new data_req presented in the data_done cycle -> second arvalid rises 1 cycle after done; no duplicate AR.
- rst asserted while in RD_DATA -> next cycle all valids/readies/done = 0, FSM IDLE; a subsequent fetch completes normally.
- awready and wready both high in the first cycle of WR_REQ -> both valids drop together, WR_RESP entered next cycle.

Source files
------------

// File: rtl/axi_sram_bridge_if.sv
// AXI3 single-beat master bus used by axi_sram_bridge; the master modport is
// the bridge side, the slave modport is the memory/interconnect side.
interface axi_sram_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_bridge.sv
// Bridges the SRAM-like fetch and data ports onto one AXI3 master, one
// single-beat transaction outstanding; data requests win over fetches.
module axi_sram_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,

  axi_sram_bridge_if.master axi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_t;

  state_t      state;
  logic        src_data;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic        awvalid_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wvalid_q;
  logic        bready_q;

  // Response IDs/status are irrelevant with a single outstanding transaction.
  logic unused_ok;
  assign unused_ok = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  logic aw_complete;
  logic w_complete;
  assign aw_complete = !awvalid_q || axi.awready;
  assign w_complete  = !wvalid_q  || axi.wready;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_data   <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      awvalid_q  <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            src_data <= 1'b1;
            if (data_wr) begin
              awaddr_q  <= data_addr;
              awsize_q  <= {1'b0, data_size};
              wdata_q   <= data_wdata;
              wstrb_q   <= data_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR_REQ;
            end else begin
              arid_q    <= DATA_ID;
              araddr_q  <= data_addr;
              arsize_q  <= {1'b0, data_size};
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end else if (inst_req) begin
            src_data  <= 1'b0;
            arid_q    <= INST_ID;
            araddr_q  <= inst_addr;
            arsize_q  <= 3'd2;
            arvalid_q <= 1'b1;
            state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            if (src_data) begin
              data_rdata <= axi.rdata;
              data_done  <= 1'b1;
            end else begin
              inst_rdata <= axi.rdata;
              inst_done  <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; a channel already done counts as complete.
          if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
          if (aw_complete && w_complete) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.bvalid) begin
            bready_q  <= 1'b0;
            data_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge: the bench plays the AXI slave cycle by
// cycle and checks every registered output against hand-derived values.
module tb_axi_sram_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_done;

  axi_sram_bridge_if bus ();

  axi_sram_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_done(inst_done),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .axi(bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned ar_hs = 0;
  int unsigned aw_hs = 0;
  int unsigned w_hs = 0;
  int unsigned inst_done_n = 0;
  int unsigned data_done_n = 0;
  int unsigned ar_base;
  int unsigned done_base;

  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;
    if (bus.awvalid && bus.awready) aw_hs <= aw_hs + 1;
    if (bus.wvalid && bus.wready) w_hs <= w_hs + 1;
    if (inst_done) inst_done_n <= inst_done_n + 1;
    if (data_done) data_done_n <= data_done_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " valids/readies/done"},
        {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, inst_done, data_done},
        32'd0);
  endtask

  initial begin
    bus.arready = 1'b0;
    bus.rid = 4'hF; bus.rdata = '0; bus.rresp = 2'b10; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bid = 4'hE; bus.bresp = 2'b11; bus.bvalid = 1'b0;

    // Reset state
    tick(); tick();
    chk_idle_outputs("reset");
    chk("reset inst_rdata", inst_rdata, 32'h0);
    chk("reset data_rdata", data_rdata, 32'h0);
    chk("reset araddr", bus.araddr, 32'h0);
    chk("reset awaddr/wstrb", {bus.awaddr[27:0], bus.wstrb}, 32'h0);
    chk("constants", {bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot,
                      bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.wlast},
        {4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
    rst = 1'b0;
    tick();

    // Fetch with delayed arready and rvalid
    ar_base = ar_hs; done_base = inst_done_n;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    tick();
    chk("f1 arvalid", bus.arvalid, 1);
    chk("f1 araddr", bus.araddr, 32'hBFC00000);
    chk("f1 arid/arsize/arlen", {bus.arid, bus.arsize, bus.arlen}, {4'd0, 3'd2, 4'd0});
    tick();
    chk("f1 arvalid held", bus.arvalid, 1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("f1 ar dropped, rready", {bus.arvalid, bus.rready}, 2'b01);
    tick(); tick();
    chk("f1 waiting rready", {bus.rready, inst_done}, 2'b10);
    bus.rvalid = 1'b1; bus.rdata = 32'h3C08BFC0;
    tick();
    bus.rvalid = 1'b0; inst_req = 1'b0;
    chk("f1 inst_done", inst_done, 1);
    chk("f1 inst_rdata", inst_rdata, 32'h3C08BFC0);
    chk("f1 rready cleared", bus.rready, 0);
    tick();
    chk("f1 done one cycle", inst_done, 0);
    tick();
    chk("f1 ar count", ar_hs - ar_base, 1);
    chk("f1 done count", inst_done_n - done_base, 1);
    chk("f1 inst_rdata held", inst_rdata, 32'h3C08BFC0);

    // Byte store, wready first, awready three cycles later
    done_base = data_done_n;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h80001003;
    data_wstrb = 4'b1000; data_wdata = 32'hAB000000;
    tick();
    chk("st aw/w valid", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b110);
    chk("st awaddr", bus.awaddr, 32'h80001003);
    chk("st awsize/wstrb/ids", {bus.awsize, bus.wstrb, bus.awid, bus.wid}, {3'd0, 4'b1000, 4'd1, 4'd1});
    chk("st wdata", bus.wdata, 32'hAB000000);
    bus.wready = 1'b1;
    tick();
    bus.wready = 1'b0;
    chk("st w dropped alone", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    tick(); tick();
    chk("st still waiting aw", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
    bus.awready = 1'b1;
    tick();
    bus.awready = 1'b0;
    chk("st bready after both", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    tick();
    chk("st no done before bvalid", data_done, 0);
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    chk("st data_done/bready", {data_done, bus.bready}, 2'b10);
    tick();
    chk("st done one cycle", data_done, 0);
    tick();
    chk("st hs counts", {aw_hs[15:0], w_hs[15:0]}, {16'd1, 16'd1});
    chk("st done count", data_done_n - done_base, 1);

    // Simultaneous inst and data load requests: data first
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h80000010;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    tick();
    chk("pri data ar first", {bus.arvalid, bus.arid}, {1'b1, 4'd1});
    chk("pri data araddr", bus.araddr, 32'h80000010);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h11223344;
    tick();
    bus.rvalid = 1'b0; data_req = 1'b0;
    chk("pri data_done/inst_done", {data_done, inst_done}, 2'b10);
    chk("pri data_rdata", data_rdata, 32'h11223344);
    chk("pri no inst ar yet", bus.arvalid, 0);
    tick();
    chk("pri inst ar after done", {bus.arvalid, bus.arid}, {1'b1, 4'd0});
    chk("pri inst araddr", bus.araddr, 32'hBFC00004);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h55667788;
    tick();
    bus.rvalid = 1'b0; inst_req = 1'b0;
    chk("pri inst_done", inst_done, 1);
    chk("pri inst_rdata", inst_rdata, 32'h55667788);
    chk("pri data_rdata held", data_rdata, 32'h11223344);
    tick();

    // Back-to-back loads: replacement request in the done cycle
    ar_base = ar_hs;
    data_req = 1'b1; data_size = 2'd1; data_addr = 32'h80000102;
    tick();
    chk("b2b ar1 arsize", {bus.arvalid, bus.arsize}, {1'b1, 3'd1});
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA5A50001;
    tick();
    bus.rvalid = 1'b0; data_addr = 32'h80000200; data_size = 2'd2;
    chk("b2b done1", {data_done, bus.arvalid}, 2'b10);
    tick();
    chk("b2b ar2 one cycle later", {bus.arvalid, data_done}, 2'b10);
    chk("b2b ar2 addr", bus.araddr, 32'h80000200);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA5A50002;
    tick();
    bus.rvalid = 1'b0; data_req = 1'b0;
    chk("b2b done2 rdata", data_rdata, 32'hA5A50002);
    tick(); tick();
    chk("b2b ar count", ar_hs - ar_base, 2);
    chk("b2b no extra ar", bus.arvalid, 0);

    // Reset while waiting in RD_DATA
    done_base = inst_done_n;
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    tick();
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("rst pre rready", bus.rready, 1);
    rst = 1'b1; inst_req = 1'b0;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst mid");
    chk("rst inst_rdata", inst_rdata, 32'h0);
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD0000;
    tick();
    bus.rvalid = 1'b0;
    tick();
    chk("rst abandoned no done", inst_done_n - done_base, 0);
    inst_req = 1'b1; inst_addr = 32'hBFC00200;
    tick();
    chk("rst refetch ar", {bus.arvalid, bus.araddr[15:0]}, {1'b1, 16'h0200});
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h24020001;
    tick();
    bus.rvalid = 1'b0; inst_req = 1'b0;
    chk("rst refetch done", {inst_done, inst_rdata}, {1'b1, 32'h24020001});
    tick();

    // Both readies high in the first WR_REQ cycle
    done_base = data_done_n;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h80000020;
    data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
    tick();
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("sim both dropped, bready", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
    bus.bvalid = 1'b1;
    tick();
    bus.bvalid = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    chk("sim data_done", data_done, 1);
    tick(); tick();
    chk("sim done count", data_done_n - done_base, 1);
    chk_idle_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
